// File: rtl/mem_burst_ctrl.sv
// Burst sequencer in front of a 16-bit word memory with one-cycle registered read.
// Multi-word bursts are built only when MEM_CTRL_BURST_EN is defined; otherwise every request moves one word.
module mem_burst_ctrl #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [15:0]           wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [15:0]           rd_data,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_load,
  output logic                  mem_out_en,
  output logic [15:0]           mem_data_in,
  input  logic [15:0]           mem_data_out
);

  localparam int unsigned DATA_WIDTH = 16;

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_WRITE        = 3'd1;
  localparam logic [2:0] S_READ_ISSUE   = 3'd2;
  localparam logic [2:0] S_READ_CAPTURE = 3'd3;
  localparam logic [2:0] S_READ_PRESENT = 3'd4;

  logic [2:0]            state, state_nx;
  logic [ADDR_WIDTH-1:0] addr, addr_nx;
  logic [DATA_WIDTH-1:0] rd_data_nx;
  logic                  rd_valid_nx;
  logic                  done_nx;
  logic                  last;

`ifdef MEM_CTRL_BURST_EN
  logic [LEN_WIDTH-1:0]  remaining, remaining_nx;
  assign last = (remaining == '0);
`else
  logic unused_len;
  assign unused_len = ^req_len;
  assign last = 1'b1;
`endif

  // Next-state and register-update logic
  always_comb begin
    state_nx    = state;
    addr_nx     = addr;
    rd_data_nx  = rd_data;
    rd_valid_nx = rd_valid;
    done_nx     = 1'b0;
`ifdef MEM_CTRL_BURST_EN
    remaining_nx = remaining;
`endif
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          addr_nx  = req_addr;
`ifdef MEM_CTRL_BURST_EN
          remaining_nx = req_len;
`endif
          state_nx = req_write ? S_WRITE : S_READ_ISSUE;
        end
      end
      S_WRITE: begin
        if (wr_valid) begin
          if (last) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end else begin
`ifdef MEM_CTRL_BURST_EN
            addr_nx      = addr + ADDR_WIDTH'(1);
            remaining_nx = remaining - LEN_WIDTH'(1);
`endif
          end
        end
      end
      S_READ_ISSUE: begin
        state_nx = S_READ_CAPTURE;
      end
      S_READ_CAPTURE: begin
        rd_data_nx  = mem_data_out;
        rd_valid_nx = 1'b1;
        state_nx    = S_READ_PRESENT;
      end
      S_READ_PRESENT: begin
        if (rd_valid && rd_ready) begin
          rd_valid_nx = 1'b0;
          if (last) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end else begin
`ifdef MEM_CTRL_BURST_EN
            addr_nx      = addr + ADDR_WIDTH'(1);
            remaining_nx = remaining - LEN_WIDTH'(1);
`endif
            state_nx = S_READ_ISSUE;
          end
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      addr     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
`ifdef MEM_CTRL_BURST_EN
      remaining <= '0;
`endif
    end else begin
      state    <= state_nx;
      addr     <= addr_nx;
      rd_data  <= rd_data_nx;
      rd_valid <= rd_valid_nx;
      done     <= done_nx;
`ifdef MEM_CTRL_BURST_EN
      remaining <= remaining_nx;
`endif
    end
  end

  // Memory strobes decode straight from state so reset removes them without waiting for a clock
  assign req_ready   = (state == S_IDLE);
  assign wr_ready    = (state == S_WRITE);
  assign mem_load    = (state == S_WRITE) && wr_valid;
  assign mem_out_en  = (state == S_READ_ISSUE);
  assign mem_address = addr;
  assign mem_data_in = (state == S_WRITE) ? wr_data : '0;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl with a registered-read memory model and write/read scoreboards.
// Expectations follow MEM_CTRL_BURST_EN: one word per request when it is undefined.
module tb_mem_burst_ctrl;

`ifdef MEM_CTRL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [3:0]  req_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        done;
  logic [15:0] mem_address;
  logic        mem_load;
  logic        mem_out_en;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;

  mem_burst_ctrl #(.ADDR_WIDTH(16), .LEN_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done),
    .mem_address(mem_address), .mem_load(mem_load), .mem_out_en(mem_out_en),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem     [65536];
  logic [15:0] ref_mem [65536];
  logic [15:0] exp_rd [$];
  logic [31:0] exp_wr [$];
  int n_cmp   = 0;
  int n_err   = 0;
  int done_cnt = 0;
  int rd_cnt   = 0;

  // Word memory: write and registered read on the same edge
  always @(posedge clk) begin
    if (mem_load) mem[mem_address] <= mem_data_in;
    if (mem_out_en) mem_data_out <= mem[mem_address];
  end

  // Scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      if (mem_load || mem_out_en) begin
        n_cmp++;
        if (mem_load && mem_out_en) begin
          n_err++;
          $display("FAIL strobe_exclusive load=%b out_en=%b want not both", mem_load, mem_out_en);
        end
      end
      if (mem_load) begin
        n_cmp++;
        if (exp_wr.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write addr=%h data=%h want no write", mem_address, mem_data_in);
        end else begin
          logic [31:0] e;
          e = exp_wr.pop_front();
          if ({mem_address, mem_data_in} !== e) begin
            n_err++;
            $display("FAIL write_beat got addr/data=%h/%h want %h/%h", mem_address, mem_data_in, e[31:16], e[15:0]);
          end
        end
      end
      if (rd_valid && rd_ready) begin
        rd_cnt++;
        n_cmp++;
        if (exp_rd.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_read rd_data=%h want no read", rd_data);
        end else begin
          logic [15:0] e;
          e = exp_rd.pop_front();
          if (rd_data !== e) begin
            n_err++;
            $display("FAIL read_word rd_data=%h want %h", rd_data, e);
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  function automatic int nwords(input logic [3:0] len);
    return BURST ? int'(len) + 1 : 1;
  endfunction

  task automatic issue(input logic wr, input logic [15:0] a, input logic [3:0] len);
    int t;
    logic [15:0] ad;
    t = 0;
    while (req_ready !== 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL issue_timeout req_ready=%b want 1", req_ready);
    end
    req_write = wr; req_addr = a; req_len = len; req_valid = 1'b1;
    if (!wr) begin
      for (int i = 0; i < nwords(len); i++) begin
        ad = a + 16'(i);
        exp_rd.push_back(ref_mem[ad]);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 16'($urandom);
    req_len   = 4'($urandom);
  endtask

  task automatic write_words(input logic [15:0] a, input int n, input logic [15:0] base,
                             input logic [15:0] step, output int stalls);
    int t;
    logic [15:0] ad;
    logic [15:0] d;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      ad = a + 16'(i);
      d  = base + step * 16'(i);
      wr_data = d; wr_valid = 1'b1;
      t = 0;
      while (wr_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; stalls++; end
      exp_wr.push_back({ad, d});
      ref_mem[ad] = d;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL %s_done_timeout done=%b want 1", name, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b1; req_write = 1'b1; wr_valid = 1'b1; wr_data = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({req_ready, wr_ready, rd_valid, done, mem_load, mem_out_en} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_flags got=%b want=100000", {req_ready, wr_ready, rd_valid, done, mem_load, mem_out_en});
    end
    n_cmp++;
    if ({rd_data, mem_address, mem_data_in} !== 48'h0) begin
      n_err++;
      $display("FAIL reset_data rd_data=%h mem_address=%h mem_data_in=%h want 0", rd_data, mem_address, mem_data_in);
    end
    req_valid = 1'b0; wr_valid = 1'b0; wr_data = 16'h0;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int st;
    int d0;
    d0 = done_cnt;
    rd_ready = 1'b1;
    issue(1'b1, 16'h0010, 4'd0);
    write_words(16'h0010, 1, 16'hBEEF, 16'h0, st);
    n_cmp++;
    if ({done, req_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL single_write_done done/req_ready=%b want 11", {done, req_ready});
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle done=%b want 0", done); end
    issue(1'b0, 16'h0010, 4'd0);
    n_cmp++;
    if ({mem_out_en, mem_address, rd_valid} !== {1'b1, 16'h0010, 1'b0}) begin
      n_err++;
      $display("FAIL read_issue out_en=%b addr=%h rd_valid=%b want 1/0010/0", mem_out_en, mem_address, rd_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({rd_valid, mem_out_en} !== 2'b00) begin
      n_err++;
      $display("FAIL read_capture rd_valid/out_en=%b want 00", {rd_valid, mem_out_en});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({rd_valid, rd_data} !== {1'b1, 16'hBEEF}) begin
      n_err++;
      $display("FAIL read_latency rd_valid=%b rd_data=%h want 1/beef", rd_valid, rd_data);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({done, rd_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL single_read_done done/rd_valid=%b want 10", {done, rd_valid});
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done_cnt !== d0 + 2) begin
      n_err++;
      $display("FAIL single_done_count got=%0d want=%0d", done_cnt - d0, 2);
    end
  endtask

  task automatic test_write_burst();
    int st;
    int d0;
    d0 = done_cnt;
    issue(1'b1, 16'h0100, 4'd3);
    write_words(16'h0100, nwords(4'd3), 16'h1111, 16'h1111, st);
    n_cmp++;
    if (st !== 0) begin n_err++; $display("FAIL burst_stalls got=%0d want=0", st); end
    n_cmp++;
    if ({done, req_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL burst_done done/req_ready=%b want 11", {done, req_ready});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({done, done_cnt - d0, exp_wr.size()} !== {1'b0, 32'd1, 32'd0}) begin
      n_err++;
      $display("FAIL burst_end done=%b done_count=%0d pending_writes=%0d want 0/1/0", done, done_cnt - d0, exp_wr.size());
    end
  endtask

  task automatic test_read_backpressure();
    int t;
    int d0;
    d0 = done_cnt;
    rd_ready = 1'b0;
    issue(1'b0, 16'h0100, 4'd1);
    t = 0;
    while (rd_valid !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    n_cmp++;
    if (rd_valid !== 1'b1) begin n_err++; $display("FAIL bp_rd_valid rd_valid=%b want 1", rd_valid); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({rd_valid, rd_data, mem_out_en, done} !== {1'b1, 16'h1111, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold cyc=%0d rd_valid=%b rd_data=%h out_en=%b done=%b want 1/1111/0/0",
                 i, rd_valid, rd_data, mem_out_en, done);
      end
    end
    rd_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({mem_out_en, done} !== (BURST ? 2'b10 : 2'b01)) begin
      n_err++;
      $display("FAIL bp_release out_en/done=%b want %b", {mem_out_en, done}, (BURST ? 2'b10 : 2'b01));
    end
    wait_done("bp");
    @(posedge clk); #1;
    n_cmp++;
    if ({done_cnt - d0, exp_rd.size()} !== {32'd1, 32'd0}) begin
      n_err++;
      $display("FAIL bp_end done_count=%0d pending_reads=%0d want 1/0", done_cnt - d0, exp_rd.size());
    end
  endtask

  task automatic test_wrap();
    int st;
    int d0;
    d0 = done_cnt;
    rd_ready = 1'b1;
    issue(1'b1, 16'hFFFE, 4'd2);
    write_words(16'hFFFE, nwords(4'd2), 16'hC001, 16'h0001, st);
    issue(1'b0, 16'hFFFE, 4'd2);
    wait_done("wrap_read");
    @(posedge clk); #1;
    n_cmp++;
    if ({done_cnt - d0, exp_rd.size(), exp_wr.size()} !== {32'd2, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL wrap_end done_count=%0d pending_reads=%0d pending_writes=%0d want 2/0/0",
               done_cnt - d0, exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    int d0;
    issue(1'b1, 16'h0200, 4'd3);
    d0 = done_cnt;
    wr_data = 16'hA001; wr_valid = 1'b1;
    exp_wr.push_back({16'h0200, 16'hA001});
    ref_mem[16'h0200] = 16'hA001;
    @(posedge clk); #1;
    wr_data = 16'hA002;
    #1;
    n_cmp++;
    if (mem_load !== BURST) begin n_err++; $display("FAIL rst_beat2_load got=%b want=%b", mem_load, BURST); end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({mem_load, mem_out_en, req_ready, wr_ready, done} !== 5'b00100) begin
      n_err++;
      $display("FAIL rst_async load/out_en/req_ready/wr_ready/done=%b want 00100",
               {mem_load, mem_out_en, req_ready, wr_ready, done});
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({mem_load, done, req_ready} !== 3'b001) begin
        n_err++;
        $display("FAIL rst_after cyc=%0d load/done/req_ready=%b want 001", i, {mem_load, done, req_ready});
      end
    end
    wr_valid = 1'b0;
    n_cmp++;
    if (done_cnt !== d0) begin n_err++; $display("FAIL rst_no_done got=%0d want=%0d", done_cnt, d0); end
    rd_ready = 1'b1;
    issue(1'b0, 16'h0200, 4'd3);
    wait_done("rst_readback");
    @(posedge clk); #1;
    n_cmp++;
    if ({exp_rd.size(), exp_wr.size()} !== 64'd0) begin
      n_err++;
      $display("FAIL rst_readback pending_reads=%0d pending_writes=%0d want 0/0", exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_len_ignore();
    int d0;
    int r0;
    d0 = done_cnt;
    r0 = rd_cnt;
    rd_ready = 1'b1;
    issue(1'b0, 16'h0100, 4'd5);
    wait_done("len");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({rd_valid, mem_out_en} !== 2'b00) begin
        n_err++;
        $display("FAIL len_quiet cyc=%0d rd_valid/out_en=%b want 00", i, {rd_valid, mem_out_en});
      end
    end
    n_cmp++;
    if ({rd_cnt - r0, done_cnt - d0} !== {nwords(4'd5), 32'd1}) begin
      n_err++;
      $display("FAIL len_words words=%0d done_count=%0d want %0d/1", rd_cnt - r0, done_cnt - d0, nwords(4'd5));
    end
  endtask

  task automatic test_back_to_back();
    int st;
    issue(1'b1, 16'h0300, 4'd0);
    write_words(16'h0300, 1, 16'h5A5A, 16'h0, st);
    issue(1'b1, 16'h0301, 4'd0);
    n_cmp++;
    if ({wr_ready, mem_address} !== {1'b1, 16'h0301}) begin
      n_err++;
      $display("FAIL b2b_accept wr_ready=%b addr=%h want 1/0301", wr_ready, mem_address);
    end
    write_words(16'h0301, 1, 16'h6B6B, 16'h0, st);
    rd_ready = 1'b1;
    issue(1'b0, 16'h0300, 4'd0);
    wait_done("b2b_read0");
    issue(1'b0, 16'h0301, 4'd0);
    wait_done("b2b_read1");
    @(posedge clk); #1;
    n_cmp++;
    if ({exp_rd.size(), exp_wr.size()} !== 64'd0) begin
      n_err++;
      $display("FAIL b2b_end pending_reads=%0d pending_writes=%0d want 0/0", exp_rd.size(), exp_wr.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'h0;
      ref_mem[i] = 16'h0;
    end
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0; req_len = 4'h0;
    wr_valid = 1'b0; wr_data = 16'h0; rd_ready = 1'b0;
    test_reset();
    test_single();
    test_write_burst();
    test_read_backpressure();
    test_wrap();
    test_reset_mid_burst();
    test_len_ignore();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
